// File: rtl/lfsr_descrambler_if.sv
// Word stream bundle for the LFSR descrambler: scrambled words in, descrambled words
// and lock status out, each direction with valid/ready flow control.
interface lfsr_descrambler_if #(
    parameter int WS = 7
);
    logic          i_valid;
    logic          o_ready;
    logic [WS-1:0] i_word;
    logic          i_sync;
    logic          o_valid;
    logic          i_ready;
    logic [WS-1:0] o_word;
    logic          o_locked;

    modport master (
        output i_valid, i_word, i_sync, i_ready,
        input  o_ready, o_valid, o_word, o_locked
    );

    modport slave (
        input  i_valid, i_word, i_sync, i_ready,
        output o_ready, o_valid, o_word, o_locked
    );
endinterface

// File: rtl/lfsr_descrambler.sv
// Streaming LFSR descrambler: WS bits per accepted word, multiplicative or additive,
// with one registered output stage and a sticky lock indicator.
module lfsr_descrambler #(
    parameter int             WS           = 7,
    parameter int             LN           = 31,
    parameter logic [LN-1:0]  TAPS         = LN'(31'h0000_2001),
    parameter logic [LN-1:0]  INITIAL_FILL = LN'(1),
    parameter int             MODE         = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    lfsr_descrambler_if.slave  bus
);
    localparam int CW = $clog2(LN + WS) + 1;

    typedef enum logic {UNLOCKED, LOCKED} lock_t;

    lock_t          lock_q, lock_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [LN-1:0]  lfsr_q, lfsr_d;
    logic [LN-1:0]  s;
    logic [WS-1:0]  word_d, word_q;
    logic           valid_q, locked_q;
    logic           accept, b, p;

    assign bus.o_ready  = !valid_q || bus.i_ready;
    assign bus.o_valid  = valid_q;
    assign bus.o_word   = word_q;
    assign bus.o_locked = locked_q;
    assign accept       = bus.i_valid && bus.o_ready;

    // All WS bits unrolled; MSB first. A sync in additive mode restarts from the fill.
    always_comb begin
        s      = (MODE != 0 && bus.i_sync) ? INITIAL_FILL : lfsr_q;
        word_d = '0;
        b      = 1'b0;
        p      = 1'b0;
        for (int k = 0; k < WS; k++) begin
            b                = bus.i_word[WS-1-k];
            p                = ^(s & TAPS);
            word_d[WS-1-k]   = b ^ p;
            s                = {(MODE != 0) ? p : b, s[LN-1:1]};
        end
        lfsr_d = s;
    end

    always_comb begin
        lock_d = lock_q;
        cnt_d  = cnt_q;
        if (accept) begin
            if (MODE == 0) begin
                if (cnt_q < CW'(LN))
                    cnt_d = cnt_q + CW'(WS);
                if (cnt_d >= CW'(LN))
                    lock_d = LOCKED;
            end else if (bus.i_sync) begin
                lock_d = LOCKED;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) lock_q <= UNLOCKED;
        else         lock_q <= lock_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lfsr_q   <= INITIAL_FILL;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            word_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                lfsr_q   <= lfsr_d;
                valid_q  <= 1'b1;
                word_q   <= word_d;
                locked_q <= (lock_d == LOCKED);
            end else if (bus.i_ready) begin
                valid_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lfsr_descrambler.sv
// Bench for lfsr_descrambler: one multiplicative and one additive instance checked every
// cycle against a bit-history model, plus literal expectations and a scrambler round trip.
module tb_lfsr_descrambler;
    localparam int            WS   = 7;
    localparam int            LN   = 31;
    localparam logic [LN-1:0] TAPS = 31'h0000_2001;
    localparam logic [LN-1:0] INIT = 31'h1;
    localparam int            HN   = 8192;

    logic clk, i_reset;
    lfsr_descrambler_if #(.WS(WS)) bus0();
    lfsr_descrambler_if #(.WS(WS)) bus1();

    lfsr_descrambler #(.WS(WS), .LN(LN), .TAPS(TAPS), .INITIAL_FILL(INIT), .MODE(0))
        dut0 (.i_clk(clk), .i_reset(i_reset), .bus(bus0));
    lfsr_descrambler #(.WS(WS), .LN(LN), .TAPS(TAPS), .INITIAL_FILL(INIT), .MODE(1))
        dut1 (.i_clk(clk), .i_reset(i_reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: full bit history, index 0..LN-1 holds the fill (oldest first). Each new bit
    // sees tap j at history position (now - LN + j). kind 0 = multiplicative descrambler,
    // 1 = additive descrambler, 2 = multiplicative scrambler (history holds its output).
    bit hist [3][HN];
    int hlen [3];

    function automatic void hreset(input int i, input logic [LN-1:0] fill);
        for (int j = 0; j < LN; j++) hist[i][j] = fill[j];
        hlen[i] = LN;
    endfunction

    function automatic logic [WS-1:0] lfsr_word(input int i, input int kind, input logic [WS-1:0] w);
        logic [WS-1:0] r;
        bit bb, pp, oo;
        r = '0;
        for (int k = 0; k < WS; k++) begin
            bb = w[WS-1-k];
            pp = 1'b0;
            for (int j = 0; j < LN; j++)
                if (TAPS[j]) pp ^= hist[i][hlen[i] - LN + j];
            oo = bb ^ pp;
            r[WS-1-k] = oo;
            hist[i][hlen[i]] = (kind == 0) ? bb : (kind == 1) ? pp : oo;
            hlen[i]++;
        end
        return r;
    endfunction

    wire [1:0]          m_iv   = {bus1.i_valid, bus0.i_valid};
    wire [1:0]          m_ordy = {bus1.o_ready, bus0.o_ready};
    wire [1:0]          m_is   = {bus1.i_sync,  bus0.i_sync};
    wire [1:0]          m_ov   = {bus1.o_valid, bus0.o_valid};
    wire [1:0]          m_ir   = {bus1.i_ready, bus0.i_ready};
    wire [1:0]          m_ol   = {bus1.o_locked, bus0.o_locked};
    wire [1:0][WS-1:0]  m_iw   = {bus1.i_word, bus0.i_word};
    wire [1:0][WS-1:0]  m_ow   = {bus1.o_word, bus0.o_word};

    bit            mok = 0;
    bit            ev [2];
    bit            el [2];
    logic [WS-1:0] ew [2];
    int            bits0 = 0;
    bit            seen1 = 0;
    logic [WS:0]   outlog [$];

    // Compare against the model, then advance the model by what the next edge will do.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mok) begin
                chk($sformatf("d%0d o_valid", d), m_ov[d], ev[d]);
                chk($sformatf("d%0d o_ready", d), m_ordy[d], !ev[d] || m_ir[d]);
                if (ev[d]) begin
                    chk($sformatf("d%0d o_word", d), m_ow[d], ew[d]);
                    chk($sformatf("d%0d o_locked", d), m_ol[d], el[d]);
                end
            end
            if (d == 0 && m_ov[0] && m_ir[0]) outlog.push_back({m_ol[0], m_ow[0]});
            if (i_reset) begin
                hreset(d, INIT);
                ev[d] = 0; el[d] = 0; ew[d] = '0;
                if (d == 0) bits0 = 0; else seen1 = 0;
            end else if (m_iv[d] && m_ordy[d]) begin
                if (d == 1 && m_is[1]) begin
                    hreset(1, INIT);
                    seen1 = 1;
                end
                ew[d] = lfsr_word(d, d, m_iw[d]);
                ev[d] = 1;
                if (d == 0) begin
                    bits0 += WS;
                    el[0] = (bits0 >= LN);
                end else begin
                    el[1] = seen1;
                end
            end else if (m_ir[d]) begin
                ev[d] = 0;
            end
        end
        if (i_reset) mok = 1;
    end

    bit acc0;
    task automatic cycle();
        @(negedge clk);
        acc0 = bus0.i_valid && bus0.o_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WS-1:0] d, c, hold;
        int n, guard;
        bit stalled;

        i_reset = 1;
        bus0.i_valid = 0; bus0.i_word = '0; bus0.i_sync = 0; bus0.i_ready = 1;
        bus1.i_valid = 0; bus1.i_word = '0; bus1.i_sync = 0; bus1.i_ready = 1;
        cycle(); cycle();

        chk("rst o_valid", bus0.o_valid, 0);
        chk("rst o_word", bus0.o_word, 0);
        chk("rst o_locked", bus0.o_locked, 0);
        chk("rst o_ready", bus0.o_ready, 1);
        chk("rst state", dut0.lfsr_q, 31'h1);
        chk("rst d1 o_valid", bus1.o_valid, 0);
        i_reset = 0;

        // Multiplicative, all-zero input
        bus0.i_valid = 1; bus0.i_word = '0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk($sformatf("mz word %0d", i), bus0.o_word, (i == 0) ? 7'h40 : 7'h00);
            chk($sformatf("mz lock %0d", i), bus0.o_locked, i >= 4);
        end
        bus0.i_valid = 0;
        cycle();

        // Round trip through a scrambler with a random fill. The fill bits still visible
        // to the first locked word (the top few) must agree with INIT, hence the mask.
        i_reset = 1; cycle(); i_reset = 0;
        hreset(2, LN'($urandom) & 31'h007F_FFFF);
        outlog.delete();
        begin
            logic [WS-1:0] rt_data [$];
            n = 0; guard = 0; stalled = 0;
            d = WS'($urandom); c = lfsr_word(2, 2, d);
            bus0.i_valid = 1; bus0.i_word = c; bus0.i_ready = 1;
            while (n < 40 && guard < 400) begin
                if (n == 20 && !stalled) begin
                    stalled = 1;
                    bus0.i_ready = 0;
                    hold = bus0.o_word;
                    repeat (3) begin
                        @(negedge clk);
                        chk("stall o_ready", bus0.o_ready, 0);
                        chk("stall o_valid", bus0.o_valid, 1);
                        chk("stall o_word", bus0.o_word, hold);
                        @(posedge clk); #1;
                    end
                    bus0.i_ready = 1;
                end
                cycle(); guard++;
                if (acc0) begin
                    rt_data.push_back(d); n++;
                    d = WS'($urandom); c = lfsr_word(2, 2, d);
                    bus0.i_word = c;
                end
            end
            chk("rt no timeout", guard < 400, 1);
            bus0.i_valid = 0;
            cycle(); cycle();
            chk("rt count", outlog.size(), 40);
            for (int i = 0; i < outlog.size() && i < rt_data.size(); i++) begin
                chk($sformatf("rt lock %0d", i), outlog[i][WS], i >= 4);
                if (outlog[i][WS]) chk($sformatf("rt data %0d", i), outlog[i][WS-1:0], rt_data[i]);
            end
        end

        // Additive mode
        bus1.i_valid = 1; bus1.i_word = '0; bus1.i_sync = 0;
        repeat (5) begin
            cycle();
            chk("add nosync lock", bus1.o_locked, 0);
        end
        bus1.i_sync = 1; cycle();
        chk("add sync word", bus1.o_word, 7'h40);
        chk("add sync lock", bus1.o_locked, 1);
        bus1.i_sync = 0; cycle();
        chk("add 2nd word", bus1.o_word, 7'h00);
        repeat (3) cycle();
        bus1.i_sync = 1; cycle();
        chk("add resync word", bus1.o_word, 7'h40);
        chk("add resync lock", bus1.o_locked, 1);
        bus1.i_sync = 0;

        // Random traffic on both instances
        repeat (300) begin
            bus0.i_valid = ($urandom_range(0, 3) != 0);
            bus0.i_word  = WS'($urandom);
            bus0.i_sync  = 1'($urandom);
            bus0.i_ready = ($urandom_range(0, 3) != 0);
            bus1.i_valid = ($urandom_range(0, 3) != 0);
            bus1.i_word  = WS'($urandom);
            bus1.i_sync  = ($urandom_range(0, 4) == 0);
            bus1.i_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Reset while a locked word is pending under backpressure
        bus1.i_valid = 0; bus1.i_sync = 0; bus1.i_ready = 1; bus0.i_sync = 0;
        bus0.i_ready = 0; bus0.i_valid = 1; bus0.i_word = WS'($urandom);
        cycle();
        chk("pre-rst o_valid", bus0.o_valid, 1);
        chk("pre-rst o_locked", bus0.o_locked, 1);
        i_reset = 1; cycle();
        chk("mid-rst o_valid", bus0.o_valid, 0);
        chk("mid-rst o_locked", bus0.o_locked, 0);
        i_reset = 0; bus0.i_ready = 1; bus0.i_word = '0;
        cycle();
        chk("post-rst word", bus0.o_word, 7'h40);
        chk("post-rst lock", bus0.o_locked, 0);
        bus0.i_valid = 0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lfsr_descrambler.md
# lfsr_descrambler

Parametrised streaming LFSR descrambler for the SDR receive chain. It sits between the bit slicer/deframer and the packet decoder. It descrambles WS bits per accepted word in either multiplicative (self-synchronising) or additive (frame-synchronised) mode. It provides valid/ready flow control with a single registered output stage and reports descrambler lock.

## Interface
- WS, 7: bits per word; MSB is the earliest bit in time.
- LN, 31: LFSR length (polynomial degree).
- TAPS, 31'h0000_2001: LN-bit feedback tap mask.
- INITIAL_FILL, {(LN-1)'b0,1'b1}: LN-bit state loaded on reset or sync.
- MODE, 0: 0 = multiplicative, 1 = additive.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  input word valid
- o_ready  out  1  input word may be accepted
- i_word  in  WS  scrambled input word
- i_sync  in  1  frame start, qualified by accept; additive mode only
- o_valid  out  1  output word valid
- i_ready  in  1  downstream accepts output
- o_word  out  WS  descrambled word
- o_locked  out  1  descrambler state is trustworthy

## Operation
- Decided: reset is i_reset, synchronous, active-high; clock is i_clk.
- Accept occurs when i_valid && o_ready.
- o_ready = !o_valid || i_ready, combinational. Only accepted words advance state or load the output.
- Per-bit recursion runs for k = 0..WS-1. Bit b = i_word[WS-1-k]; s is the state before bit k.
  - Parity p = ^(s & TAPS).
  - Output bit o_word[WS-1-k] = b ^ p.
  - Multiplicative next state: {b, s[LN-1:1]}.
  - Additive next state: {p, s[LN-1:1]}.
- All WS bits are unrolled in one cycle. On accept, the state register takes the state after bit WS-1.
- Additive mode, accept with i_sync=1: the state is replaced by INITIAL_FILL before bit 0 of that word. The word is descrambled from INITIAL_FILL.
- Multiplicative mode ignores i_sync.
- Lock, multiplicative mode:
  - A saturating counter adds WS per accept.
  - It is ceil(log2(LN+WS))+1 bits wide and saturates at or above LN.
  - o_locked rises with the output word whose accept brings the count to ≥LN.
  - o_locked then stays high until reset.
- Lock, additive mode: o_locked rises with the output of the first word accepted with i_sync=1, and stays high until reset.
- Lock states: UNLOCKED, then LOCKED. There is no path back except reset.

## Timing
- Latency is 1 cycle: accept at cycle n gives o_word/o_valid at cycle n+1.
- Throughput is one word per cycle while i_ready=1.
- Output register rules:
  - Loads on accept.
  - o_valid clears when i_ready=1 and there is no accept.
  - o_word, o_valid and o_locked hold stable while o_valid && !i_ready.
- Simultaneous output handoff and new accept: the register reloads, o_valid stays 1, and no bubble is inserted.
- Reset values, one cycle after i_reset=1:
  - o_valid=0, o_word=0, o_locked=0.
  - state = INITIAL_FILL, lock counter = 0.
  - o_ready=1, since o_valid=0.
- Reset mid-stream: i_reset has priority over accept and sync.
  - Any word presented in the reset cycle is dropped.
  - A pending output is discarded.
- Counter saturation: no wrap. o_locked never drops from counter overflow.
- Word width: WS=1 is legal. WS > LN is legal; the recursion continues through shifted-in bits.

## Test plan
- Reset check (defaults, MODE=0): hold i_reset 2 cycles. Required: o_valid=0, o_word=0, o_locked=0, o_ready=1, and internal state 31'h1.
- Multiplicative zeros: with i_ready=1, feed i_word=0 for 6 words. Required:
  - First output 7'h40, then 7'h00.
  - o_locked=0 on outputs 1-4 and 1 from output 5 onward (35≥31 bits).
- Round trip (multiplicative): run random 7-bit data through the matching multiplicative scrambler model, which starts from a random fill. Required: from the first o_locked=1 word onward, the output equals the original data exactly.
- Backpressure: drop i_ready for 3 cycles mid-stream while i_valid=1. Required:
  - o_ready=0 during the stall.
  - o_word held constant.
  - No loss or duplication; the output sequence is identical to the unstalled run.
- Additive sync (MODE=1):
  - Feed zeros without i_sync. Required: o_locked stays 0.
  - Then assert i_sync with a zero word. Required: output 7'h40, o_locked=1, and following outputs equal the free-running LFSR sequence from INITIAL_FILL.
  - A second i_sync restarts the sequence at 7'h40.
- Reset mid-operation: assert i_reset while o_valid=1, i_ready=0 and lock is set. Required: next cycle o_valid=0 and o_locked=0, and a subsequent zero stream again produces 7'h40 first.
